// File: rtl/mips_multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback; memory stalls on mem_ready.
module mips_multicycle_controller (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [1:0] ALUop,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic       IorD,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       Branch,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       PCEn,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state_dbg
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMRD    = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWR    = 4'd5;
   localparam logic [3:0] S_EXECUTE  = 4'd6;
   localparam logic [3:0] S_ALUWB    = 4'd7;
   localparam logic [3:0] S_BRANCH   = 4'd8;
   localparam logic [3:0] S_ADDIEXEC = 4'd9;
   localparam logic [3:0] S_ADDIWB   = 4'd10;
   localparam logic [3:0] S_JUMP     = 4'd11;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_RT   = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   logic [3:0] state_q, state_d;
   logic       op_ok;

   assign op_ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RT) ||
                  (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= S_FETCH;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RT:        state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEXEC;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXECUTE:  state_d = S_ALUWB;
         S_ADDIEXEC: state_d = S_ADDIWB;
         default:    state_d = S_FETCH;
      endcase
   end

   always_comb begin
      ALUop      = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      PCSrc      = 2'b00;
      IorD       = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      Branch     = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      state_dbg  = state_q;
      case (state_q)
         S_FETCH: begin
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE: begin
            ALUSrcB    = 2'b11;
            illegal_op = !op_ok;
            instr_done = !op_ok;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: IorD = 1'b1;
         S_MEMWB: begin
            MemtoReg   = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            IorD       = 1'b1;
            MemWrite   = 1'b1;
            instr_done = mem_ready;
         end
         S_EXECUTE: begin
            ALUSrcA = 1'b1;
            ALUop   = 2'b10;
         end
         S_ALUWB: begin
            RegDst     = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUop      = 2'b01;
            PCSrc      = 2'b01;
            Branch     = 1'b1;
            instr_done = 1'b1;
         end
         S_ADDIEXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_ADDIWB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_JUMP: begin
            PCSrc      = 2'b10;
            PCWrite    = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
      // reset aborts the instruction immediately: show FETCH, write nothing
      if (!reset_n) begin
         ALUop      = 2'b00;
         ALUSrcA    = 1'b0;
         ALUSrcB    = 2'b01;
         PCSrc      = 2'b00;
         IorD       = 1'b0;
         IRWrite    = 1'b0;
         PCWrite    = 1'b0;
         Branch     = 1'b0;
         MemWrite   = 1'b0;
         RegWrite   = 1'b0;
         RegDst     = 1'b0;
         MemtoReg   = 1'b0;
         instr_done = 1'b0;
         illegal_op = 1'b0;
         state_dbg  = 4'd0;
      end
   end

   assign PCEn = PCWrite | (Branch & zero);

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed-vector bench for the multicycle MIPS controller.
// One vector per clock; inputs driven on negedge, outputs checked 1ns later.
module tb_mips_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic [1:0] ALUop;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] PCSrc;
   logic       IorD, IRWrite, PCWrite, Branch, MemWrite, RegWrite;
   logic       PCEn, RegDst, MemtoReg, instr_done, illegal_op;
   logic [3:0] state_dbg;

   mips_multicycle_controller dut (
      .clk(clk), .reset_n(reset_n), .op(op), .zero(zero),
      .mem_ready(mem_ready), .ALUop(ALUop), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .IorD(IorD), .IRWrite(IRWrite),
      .PCWrite(PCWrite), .Branch(Branch), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .PCEn(PCEn), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .instr_done(instr_done),
      .illegal_op(illegal_op), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] LW = 6'h23, SW = 6'h2b, RT = 6'h00;
   localparam logic [5:0] BEQ = 6'h04, ADDI = 6'h08, JJ = 6'h02;
   localparam logic [5:0] BAD = 6'h3f;

   // enable bits: {IorD,IRWrite,PCWrite,Branch,MemWrite,RegWrite,
   //               PCEn,RegDst,MemtoReg,instr_done,illegal_op}
   localparam logic [10:0] IOD = 11'b100_0000_0000;
   localparam logic [10:0] IRW = 11'b010_0000_0000;
   localparam logic [10:0] PCW = 11'b001_0000_0000;
   localparam logic [10:0] BR  = 11'b000_1000_0000;
   localparam logic [10:0] MW  = 11'b000_0100_0000;
   localparam logic [10:0] RW  = 11'b000_0010_0000;
   localparam logic [10:0] PCE = 11'b000_0001_0000;
   localparam logic [10:0] RD  = 11'b000_0000_1000;
   localparam logic [10:0] M2R = 11'b000_0000_0100;
   localparam logic [10:0] DN  = 11'b000_0000_0010;
   localparam logic [10:0] ILL = 11'b000_0000_0001;
   localparam logic [10:0] FE  = IRW | PCW | PCE;

   typedef struct packed {
      logic        rst;
      logic [5:0]  op;
      logic        zero;
      logic        mr;
      logic [3:0]  st;
      logic [1:0]  aluop;
      logic        srca;
      logic [1:0]  srcb;
      logic [1:0]  pcsrc;
      logic [10:0] en;
   } vec_t;

   vec_t vecs[$];
   int   nvec = 0;
   int   nbad = 0;

   task automatic add(input logic r, input logic [5:0] o, input logic z,
                      input logic m, input logic [3:0] s,
                      input logic [1:0] ao, input logic sa,
                      input logic [1:0] sb, input logic [1:0] ps,
                      input logic [10:0] e);
      vec_t v;
      v = '{r, o, z, m, s, ao, sa, sb, ps, e};
      vecs.push_back(v);
   endtask

   function automatic logic [21:0] got();
      return {state_dbg, ALUop, ALUSrcA, ALUSrcB, PCSrc,
              IorD, IRWrite, PCWrite, Branch, MemWrite, RegWrite,
              PCEn, RegDst, MemtoReg, instr_done, illegal_op};
   endfunction

   task automatic check_int(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nbad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // run one instruction from FETCH, stalling MEMRD/MEMWR for `stalls` cycles
   task automatic run_instr(input logic [5:0] o, input int stalls,
                            output int cycles, output int mw_cycles);
      int  left;
      logic done;
      left = stalls;
      cycles = 0;
      mw_cycles = 0;
      for (int c = 0; c < 20; c++) begin
         op = o;
         zero = 1'b0;
         mem_ready = 1'b1;
         if ((state_dbg == 4'd3 || state_dbg == 4'd5) && left > 0) begin
            mem_ready = 1'b0;
            left--;
         end
         #1;
         cycles++;
         if (MemWrite) mw_cycles++;
         done = instr_done;
         @(negedge clk);
         if (done) break;
      end
   endtask

   typedef struct {
      logic [5:0] op;
      int         stalls;
      int         cyc;
      int         mw;
   } run_t;

   initial begin
      vec_t v;
      logic [21:0] exp;
      run_t runs[7];
      int   cyc, mw;

      // reset held two cycles, then release into FETCH
      add(0, RT, 0, 1, 0, 2'b00, 0, 2'b01, 2'b00, 11'd0);
      add(0, RT, 0, 1, 0, 2'b00, 0, 2'b01, 2'b00, 11'd0);
      add(1, RT, 0, 1, 0, 2'b00, 0, 2'b01, 2'b00, FE);
      // R-type
      add(1, RT, 0, 1, 1, 2'b00, 0, 2'b11, 2'b00, 11'd0);
      add(1, RT, 0, 1, 6, 2'b10, 1, 2'b00, 2'b00, 11'd0);
      add(1, RT, 0, 1, 7, 2'b00, 0, 2'b00, 2'b00, RD | RW | DN);
      // lw, two stall cycles in MEMRD
      add(1, LW, 0, 1, 0, 2'b00, 0, 2'b01, 2'b00, FE);
      add(1, LW, 0, 1, 1, 2'b00, 0, 2'b11, 2'b00, 11'd0);
      add(1, LW, 0, 1, 2, 2'b00, 1, 2'b10, 2'b00, 11'd0);
      add(1, LW, 0, 0, 3, 2'b00, 0, 2'b00, 2'b00, IOD);
      add(1, LW, 0, 0, 3, 2'b00, 0, 2'b00, 2'b00, IOD);
      add(1, LW, 0, 1, 3, 2'b00, 0, 2'b00, 2'b00, IOD);
      add(1, LW, 0, 1, 4, 2'b00, 0, 2'b00, 2'b00, M2R | RW | DN);
      // beq taken, after one FETCH stall
      add(1, BEQ, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 11'd0);
      add(1, BEQ, 0, 1, 0, 2'b00, 0, 2'b01, 2'b00, FE);
      add(1, BEQ, 0, 1, 1, 2'b00, 0, 2'b11, 2'b00, 11'd0);
      add(1, BEQ, 1, 1, 8, 2'b01, 1, 2'b00, 2'b01, BR | PCE | DN);
      // beq not taken
      add(1, BEQ, 0, 1, 0, 2'b00, 0, 2'b01, 2'b00, FE);
      add(1, BEQ, 0, 1, 1, 2'b00, 0, 2'b11, 2'b00, 11'd0);
      add(1, BEQ, 0, 1, 8, 2'b01, 1, 2'b00, 2'b01, BR | DN);
      // sw
      add(1, SW, 0, 1, 0, 2'b00, 0, 2'b01, 2'b00, FE);
      add(1, SW, 0, 1, 1, 2'b00, 0, 2'b11, 2'b00, 11'd0);
      add(1, SW, 0, 1, 2, 2'b00, 1, 2'b10, 2'b00, 11'd0);
      add(1, SW, 0, 1, 5, 2'b00, 0, 2'b00, 2'b00, IOD | MW | DN);
      // j
      add(1, JJ, 0, 1, 0, 2'b00, 0, 2'b01, 2'b00, FE);
      add(1, JJ, 0, 1, 1, 2'b00, 0, 2'b11, 2'b00, 11'd0);
      add(1, JJ, 0, 1, 11, 2'b00, 0, 2'b00, 2'b10, PCW | PCE | DN);
      // illegal opcode
      add(1, BAD, 0, 1, 0, 2'b00, 0, 2'b01, 2'b00, FE);
      add(1, BAD, 0, 1, 1, 2'b00, 0, 2'b11, 2'b00, DN | ILL);
      // addi
      add(1, ADDI, 0, 1, 0, 2'b00, 0, 2'b01, 2'b00, FE);
      add(1, ADDI, 0, 1, 1, 2'b00, 0, 2'b11, 2'b00, 11'd0);
      add(1, ADDI, 0, 1, 9, 2'b00, 1, 2'b10, 2'b00, 11'd0);
      add(1, ADDI, 0, 1, 10, 2'b00, 0, 2'b00, 2'b00, RW | DN);
      // reset during a stalled MEMWR
      add(1, SW, 0, 1, 0, 2'b00, 0, 2'b01, 2'b00, FE);
      add(1, SW, 0, 1, 1, 2'b00, 0, 2'b11, 2'b00, 11'd0);
      add(1, SW, 0, 1, 2, 2'b00, 1, 2'b10, 2'b00, 11'd0);
      add(1, SW, 0, 0, 5, 2'b00, 0, 2'b00, 2'b00, IOD | MW);
      add(0, SW, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 11'd0);
      add(1, SW, 0, 1, 0, 2'b00, 0, 2'b01, 2'b00, FE);

      reset_n = 1'b0;
      op = RT;
      zero = 1'b0;
      mem_ready = 1'b1;
      @(posedge clk);

      foreach (vecs[i]) begin
         v = vecs[i];
         @(negedge clk);
         reset_n = v.rst;
         op = v.op;
         zero = v.zero;
         mem_ready = v.mr;
         #1;
         exp = {v.st, v.aluop, v.srca, v.srcb, v.pcsrc, v.en};
         nvec++;
         if (got() !== exp) begin
            nbad++;
            $display("FAIL vec%0d: got st=%0d bits=%b, expected st=%0d bits=%b",
                     i, state_dbg, got(), v.st, exp);
         end
      end

      // cycle-count sequences from a clean FETCH
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      runs[0] = '{RT, 0, 4, 0};
      runs[1] = '{ADDI, 0, 4, 0};
      runs[2] = '{SW, 0, 4, 1};
      runs[3] = '{LW, 0, 5, 0};
      runs[4] = '{BEQ, 0, 3, 0};
      runs[5] = '{JJ, 0, 3, 0};
      runs[6] = '{SW, 3, 7, 4};
      foreach (runs[i]) begin
         run_instr(runs[i].op, runs[i].stalls, cyc, mw);
         check_int($sformatf("run%0d_cycles", i), cyc, runs[i].cyc);
         check_int($sformatf("run%0d_memwrite", i), mw, runs[i].mw);
         check_int($sformatf("run%0d_back_to_fetch", i), int'(state_dbg), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
